// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the fetch sequencer and its neighbours: PC_reg, EX redirect,
// instruction memory and the ID stage. "master" is the fetch unit's view.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc_next;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;

  modport master (
    input  pc_in, redirect_valid, redirect_pc, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, id_ready,
    output pc_ld, pc_next, imem_req_valid, imem_req_addr,
           id_valid, id_instr, id_pc
  );

  modport slave (
    output pc_in, redirect_valid, redirect_pc, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, id_ready,
    input  pc_ld, pc_next, imem_req_valid, imem_req_addr,
           id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: issues imem requests from PC_reg, steers PC_reg,
// pairs in-order responses with their PCs and queues {pc, instr} for ID.
module if_fetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int FQ_DEPTH = 2,
  parameter int MAX_OUT  = 2
) (
  input logic               clk,
  input logic               rst_n,
  if_fetch_unit_if.master   io_bus
);

  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int FW  = $clog2(FQ_DEPTH);
  localparam int FCW = $clog2(FQ_DEPTH + 1);
  localparam int SW  = $clog2(FQ_DEPTH + MAX_OUT + 1);

  localparam logic [OW-1:0] MAX_OUT_C  = OW'(MAX_OUT);
  localparam logic [SW-1:0] FQ_DEPTH_C = SW'(FQ_DEPTH);
  localparam logic [PW-1:0] PCF_LAST   = PW'(MAX_OUT - 1);

  logic [OW-1:0]     r_outCnt;
  logic [OW-1:0]     r_killCnt;
  logic [ADDR_W-1:0] r_pcf [MAX_OUT];
  logic [PW-1:0]     r_pcfWr;
  logic [PW-1:0]     r_pcfRd;
  logic [ADDR_W-1:0] r_fqPc    [FQ_DEPTH];
  logic [31:0]       r_fqInstr [FQ_DEPTH];
  logic [FW-1:0]     r_fqWr;
  logic [FW-1:0]     r_fqRd;
  logic [FCW-1:0]    r_fqCnt;

  logic w_credit;
  logic w_reqValid;
  logic w_reqFire;
  logic w_rspFire;
  logic w_fqPush;
  logic w_fqPop;
  logic w_unusedBits;

  function automatic logic [PW-1:0] incPcf(input logic [PW-1:0] p);
    return (p == PCF_LAST) ? '0 : p + 1'b1;
  endfunction

  // Credit counts in-flight requests as already occupying queue slots, so the queue never overflows.
  assign w_credit   = (r_outCnt < MAX_OUT_C) &&
                      ((SW'(r_outCnt) + SW'(r_fqCnt)) < FQ_DEPTH_C);
  assign w_reqValid = rst_n && !io_bus.redirect_valid && w_credit;
  assign w_reqFire  = w_reqValid && io_bus.imem_req_ready;
  assign w_rspFire  = io_bus.imem_rsp_valid && (r_outCnt != '0);
  assign w_fqPush   = w_rspFire && (r_killCnt == '0) && !io_bus.redirect_valid;
  assign w_fqPop    = (r_fqCnt != '0) && io_bus.id_ready && !io_bus.redirect_valid;

  assign io_bus.imem_req_valid = w_reqValid;
  assign io_bus.imem_req_addr  = io_bus.pc_in;
  assign io_bus.pc_ld          = rst_n && (w_reqFire || io_bus.redirect_valid);
  assign io_bus.pc_next        = io_bus.redirect_valid
                                 ? {io_bus.redirect_pc[ADDR_W-1:2], 2'b00}
                                 : io_bus.pc_in + ADDR_W'(4);
  assign io_bus.id_valid       = (r_fqCnt != '0);
  assign io_bus.id_pc          = r_fqPc[r_fqRd];
  assign io_bus.id_instr       = r_fqInstr[r_fqRd];

  assign w_unusedBits = ^io_bus.redirect_pc[1:0];

  // kill_cnt covers responses still owed for the squashed path; one arriving this cycle is already dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outCnt  <= '0;
      r_killCnt <= '0;
      r_pcfWr   <= '0;
      r_pcfRd   <= '0;
      for (int i = 0; i < MAX_OUT; i++) r_pcf[i] <= '0;
    end else begin
      r_outCnt <= r_outCnt + OW'(w_reqFire) - OW'(w_rspFire);
      if (w_reqFire) begin
        r_pcf[r_pcfWr] <= io_bus.pc_in;
        r_pcfWr        <= incPcf(r_pcfWr);
      end
      if (w_rspFire) r_pcfRd <= incPcf(r_pcfRd);
      if (io_bus.redirect_valid)
        r_killCnt <= r_outCnt - OW'(w_rspFire);
      else if (w_rspFire && (r_killCnt != '0))
        r_killCnt <= r_killCnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fqWr  <= '0;
      r_fqRd  <= '0;
      r_fqCnt <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_fqPc[i]    <= '0;
        r_fqInstr[i] <= '0;
      end
    end else if (io_bus.redirect_valid) begin
      r_fqWr  <= '0;
      r_fqRd  <= '0;
      r_fqCnt <= '0;
    end else begin
      if (w_fqPush) begin
        r_fqPc[r_fqWr]    <= r_pcf[r_pcfRd];
        r_fqInstr[r_fqWr] <= io_bus.imem_rsp_data;
        r_fqWr            <= r_fqWr + 1'b1;
      end
      if (w_fqPop) r_fqRd <= r_fqRd + 1'b1;
      r_fqCnt <= r_fqCnt + FCW'(w_fqPush) - FCW'(w_fqPop);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a PC_reg model and an in-order imem model
// whose responses can be held back to create outstanding requests.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic clk = 1'b0;
  logic rst_n;
  logic rspEn;
  logic [31:0] pcReg;
  logic [31:0] memQ[$];
  int          qCount;
  logic [31:0] headAddr;
  int          nChecks;
  int          nErrors;

  if_fetch_unit_if #(.ADDR_W(32)) bus ();

  if_fetch_unit #(.ADDR_W(32), .FQ_DEPTH(2), .MAX_OUT(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcReg <= 32'h0;
    else if (bus.pc_ld) pcReg <= bus.pc_next;
  end
  assign bus.pc_in = pcReg;

  // imem returns one response per cycle, oldest first, only while rspEn is high; it is not reset.
  always @(posedge clk) begin
    if (rspEn && memQ.size() != 0) void'(memQ.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready) memQ.push_back(bus.imem_req_addr);
    qCount   <= memQ.size();
    headAddr <= (memQ.size() != 0) ? memQ[0] : 32'h0;
  end
  assign bus.imem_rsp_valid = rspEn && (qCount != 0);
  assign bus.imem_rsp_data  = instrOf(headAddr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] redirPc,
                               input logic reqReady, input logic idReady,
                               input logic rspEnable);
    bus.redirect_valid = redir;
    bus.redirect_pc    = redirPc;
    bus.imem_req_ready = reqReady;
    bus.id_ready       = idReady;
    rspEn              = rspEnable;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    qCount  = 0;
    headAddr = 32'h0;

    // Test 1: reset values, then streaming fetch from PC 0
    $display("[TB] reset and streaming fetch");
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("rst_pc_ld",     32'(bus.pc_ld),          32'h0);
    checkOutput("rst_id_valid",  32'(bus.id_valid),       32'h0);
    checkOutput("rst_id_pc",     bus.id_pc,               32'h0);
    checkOutput("rst_id_instr",  bus.id_instr,            32'h0);
    checkOutput("rst_req_addr",  bus.imem_req_addr,       32'h0);
    checkOutput("rst_pc_next",   bus.pc_next,             32'h4);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("t1a_req_valid", 32'(bus.imem_req_valid), 32'h1);
    checkOutput("t1a_req_addr",  bus.imem_req_addr,       32'h0);
    checkOutput("t1a_pc_ld",     32'(bus.pc_ld),          32'h1);
    checkOutput("t1a_pc_next",   bus.pc_next,             32'h4);
    tick();
    checkOutput("t1b_req_valid", 32'(bus.imem_req_valid), 32'h1);
    checkOutput("t1b_req_addr",  bus.imem_req_addr,       32'h4);
    checkOutput("t1b_id_valid",  32'(bus.id_valid),       32'h0);
    tick();
    checkOutput("t1c_id_valid",  32'(bus.id_valid),       32'h1);
    checkOutput("t1c_id_pc",     bus.id_pc,               32'h0);
    checkOutput("t1c_id_instr",  bus.id_instr,            instrOf(32'h0));
    checkOutput("t1c_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("t1c_pc_ld",     32'(bus.pc_ld),          32'h0);
    tick();
    checkOutput("t1d_id_pc",     bus.id_pc,               32'h4);
    checkOutput("t1d_id_instr",  bus.id_instr,            instrOf(32'h4));
    checkOutput("t1d_req_addr",  bus.imem_req_addr,       32'h8);
    checkOutput("t1d_req_valid", 32'(bus.imem_req_valid), 32'h1);
    tick();
    checkOutput("t1e_id_valid",  32'(bus.id_valid),       32'h0);
    checkOutput("t1e_req_addr",  bus.imem_req_addr,       32'hC);
    tick();
    checkOutput("t1f_id_pc",     bus.id_pc,               32'h8);
    checkOutput("t1f_req_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    checkOutput("t1g_id_pc",     bus.id_pc,               32'hC);
    checkOutput("t1g_req_addr",  bus.imem_req_addr,       32'h10);

    // Test 2: ID stalled, only FQ_DEPTH requests may issue
    $display("[TB] ID backpressure");
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("t2a_req_addr",  bus.imem_req_addr,       32'h0);
    tick();
    checkOutput("t2b_req_addr",  bus.imem_req_addr,       32'h4);
    checkOutput("t2b_req_valid", 32'(bus.imem_req_valid), 32'h1);
    tick();
    checkOutput("t2c_req_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    checkOutput("t2d_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("t2d_id_pc",     bus.id_pc,               32'h0);
    tick();
    checkOutput("t2e_req_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("t2f_req_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    checkOutput("t2g_req_valid", 32'(bus.imem_req_valid), 32'h1);
    checkOutput("t2g_req_addr",  bus.imem_req_addr,       32'h8);
    checkOutput("t2g_id_pc",     bus.id_pc,               32'h4);

    // Test 3: imem not ready, request must hold steady
    $display("[TB] imem stall");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("t3_req_valid", 32'(bus.imem_req_valid), 32'h1);
      checkOutput("t3_req_addr",  bus.imem_req_addr,       32'h0);
      checkOutput("t3_pc_ld",     32'(bus.pc_ld),          32'h0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_fire_pc_ld", 32'(bus.pc_ld),   32'h1);
    checkOutput("t3_fire_next",  bus.pc_next,      32'h4);
    tick();
    checkOutput("t3_after_addr", bus.imem_req_addr, 32'h4);

    // Test 4: redirect with two requests in flight
    $display("[TB] redirect kills outstanding");
    doReset();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_r0_pc_ld",   32'(bus.pc_ld),          32'h1);
    checkOutput("t4_r0_next",    bus.pc_next,             32'h10);
    checkOutput("t4_r0_valid",   32'(bus.imem_req_valid), 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_s_addr",     bus.imem_req_addr,       32'h10);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_t_addr",     bus.imem_req_addr,       32'h14);
    tick();
    applyStimulus(1'b1, 32'h103, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_u_next",     bus.pc_next,             32'h100);
    checkOutput("t4_u_valid",    32'(bus.imem_req_valid), 32'h0);
    checkOutput("t4_u_pc_ld",    32'(bus.pc_ld),          32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_v_id_valid", 32'(bus.id_valid),       32'h0);
    checkOutput("t4_v_valid",    32'(bus.imem_req_valid), 32'h0);
    tick();
    checkOutput("t4_w_id_valid", 32'(bus.id_valid),       32'h0);
    checkOutput("t4_w_addr",     bus.imem_req_addr,       32'h100);
    checkOutput("t4_w_valid",    32'(bus.imem_req_valid), 32'h1);
    tick();
    checkOutput("t4_x_id_valid", 32'(bus.id_valid),       32'h0);
    checkOutput("t4_x_addr",     bus.imem_req_addr,       32'h104);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("t4_y_id_valid", 32'(bus.id_valid),       32'h1);
    checkOutput("t4_y_id_pc",    bus.id_pc,               32'h100);
    checkOutput("t4_y_id_instr", bus.id_instr,            instrOf(32'h100));

    // Test 5: redirect coincides with a response, one request still in flight
    $display("[TB] redirect with same-cycle response");
    doReset();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_s_addr",     bus.imem_req_addr,       32'h20);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_t_addr",     bus.imem_req_addr,       32'h24);
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_u_valid",    32'(bus.imem_req_valid), 32'h0);
    checkOutput("t5_u_next",     bus.pc_next,             32'h40);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_v_id_valid", 32'(bus.id_valid),       32'h0);
    checkOutput("t5_v_valid",    32'(bus.imem_req_valid), 32'h1);
    checkOutput("t5_v_addr",     bus.imem_req_addr,       32'h40);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_w_id_valid", 32'(bus.id_valid),       32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("t5_x_id_valid", 32'(bus.id_valid),       32'h0);
    checkOutput("t5_x_pc_ld",    32'(bus.pc_ld),          32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_y_id_valid", 32'(bus.id_valid),       32'h0);
    tick();
    checkOutput("t5_z_id_valid", 32'(bus.id_valid),       32'h1);
    checkOutput("t5_z_id_pc",    bus.id_pc,               32'h40);
    checkOutput("t5_z_id_instr", bus.id_instr,            instrOf(32'h40));

    // Test 6: reset with two outstanding; the stale responses must be ignored
    $display("[TB] reset mid-stream");
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_a_addr",     bus.imem_req_addr,       32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_b_addr",     bus.imem_req_addr,       32'h4);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_c_valid",    32'(bus.imem_req_valid), 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid",  32'(bus.imem_req_valid), 32'h0);
    checkOutput("t6_rst_addr",   bus.imem_req_addr,       32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("t6_d_id_valid", 32'(bus.id_valid),       32'h0);
    checkOutput("t6_d_valid",    32'(bus.imem_req_valid), 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("t6_e_id_valid", 32'(bus.id_valid),       32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_f_id_valid", 32'(bus.id_valid),       32'h0);
    checkOutput("t6_f_pc_ld",    32'(bus.pc_ld),          32'h1);
    tick();
    checkOutput("t6_g_id_valid", 32'(bus.id_valid),       32'h0);
    tick();
    checkOutput("t6_h_id_valid", 32'(bus.id_valid),       32'h1);
    checkOutput("t6_h_id_pc",    bus.id_pc,               32'h0);
    checkOutput("t6_h_id_instr", bus.id_instr,            instrOf(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
